layer1_stats: RTL and testbench

Post-processing stage downstream of the dilated-convolution/max-pool engine. Once that engine has filled the 32×32 Layer1 feature map in shared result memory, this block scans the map through the memory read port and computes four summary statistics:
- mean value
- maximum value and its address
- count of non-zero features

It reports them with a one-cycle `done` pulse. The statistics feed the classification/debug logic and the testbench scoreboard.

---
 rtl/layer1_stats_if.sv | 15 +
 rtl/layer1_stats.sv | 171 +++++++++++++++++
 tb/tb_layer1_stats.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/layer1_stats_if.sv
// layer1_stats_if: Layer1 result-memory read port.
// Macro: none.
//   crd       read enable (master -> memory)
//   caddr_rd  12-bit read address; bits [11:10] always 0 (master -> memory)
//   csel      memory select, 1 = Layer1 (master -> memory)
//   cdata_rd  13-bit read data, arrives two edges after the address is driven (memory -> master)
interface layer1_stats_if;
    logic        crd;
    logic [11:0] caddr_rd;
    logic        csel;
    logic [12:0] cdata_rd;

    modport master (output crd, caddr_rd, csel, input cdata_rd);
    modport slave  (input crd, caddr_rd, csel, output cdata_rd);
endinterface

// File: rtl/layer1_stats.sv
// layer1_stats: scans the Layer1 feature map through the memory read port and
// reports the mean, the maximum with its first address, and the non-zero count,
// signalled by a one-cycle done pulse.
// Macro: LAYER1_STATS_ROUND_EN -- when defined, mean rounds half-up and
// saturates at 13'h0FFF; otherwise mean truncates.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        scan request, sampled only while idle
//   busy         high from the cycle after start is accepted through the done cycle
//   mem          memory read port (crd, caddr_rd, csel, cdata_rd)
//   done         one-cycle pulse when the results are valid
//   mean, max_val, max_addr, nz_cnt   result registers
module layer1_stats #(
    parameter int unsigned N_WORDS = 1024,
    parameter int unsigned LOG2_N  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    layer1_stats_if.master       mem,
    output logic                 done,
    output logic [12:0]          mean,
    output logic [12:0]          max_val,
    output logic [9:0]           max_addr,
    output logic [10:0]          nz_cnt
);

    localparam int unsigned DATA_W = 13;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned SUM_W  = 23;
    localparam int unsigned CNT_W  = 11;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WORDS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic                crd_q, crd_nxt;
    logic                csel_q, csel_nxt;
    logic [ADDR_W-1:0]   caddr_q, caddr_nxt;
    logic [ADDR_W-1:0]   rd_idx, rd_idx_nxt;
    logic                busy_nxt, done_nxt;
    logic                clr_c, fin_c;

    // Read-tracking stage: the issued crd/caddr registers form the first
    // stage, this one lines up with the data returned by the memory.
    logic                pipe_v;
    logic [ADDR_W-1:0]   pipe_a;
    logic [SUM_W-1:0]    sum;
    logic [DATA_W-1:0]   mean_c;

    assign mem.crd      = crd_q;
    assign mem.caddr_rd = {2'b00, caddr_q};
    assign mem.csel     = csel_q;

    // State and control-output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            crd_q   <= 1'b0;
            csel_q  <= 1'b0;
            caddr_q <= '0;
            rd_idx  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= busy_nxt;
            crd_q   <= crd_nxt;
            csel_q  <= csel_nxt;
            caddr_q <= caddr_nxt;
            rd_idx  <= rd_idx_nxt;
            done    <= done_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt  = state;
        busy_nxt   = busy;
        csel_nxt   = csel_q;
        crd_nxt    = 1'b0;
        caddr_nxt  = caddr_q;
        rd_idx_nxt = rd_idx;
        done_nxt   = 1'b0;
        clr_c      = 1'b0;
        fin_c      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = READ;
                    busy_nxt   = 1'b1;
                    csel_nxt   = 1'b1;
                    rd_idx_nxt = '0;
                    clr_c      = 1'b1;
                end
            end
            READ: begin
                crd_nxt    = 1'b1;
                caddr_nxt  = rd_idx;
                rd_idx_nxt = rd_idx + ADDR_W'(1);
                if (rd_idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Nothing issued and nothing in flight: last word is in the sum.
                if (!crd_q && !pipe_v) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    fin_c     = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                csel_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef LAYER1_STATS_ROUND_EN
    localparam int unsigned RND_W = SUM_W + 1;
    localparam logic [RND_W-1:0] ROUND_BIAS = RND_W'(1) << (LOG2_N - 1);
    logic [RND_W-1:0] rounded_c;
    assign rounded_c = ({1'b0, sum} + ROUND_BIAS) >> LOG2_N;
    assign mean_c    = (rounded_c > RND_W'(13'h0FFF)) ? 13'h0FFF : DATA_W'(rounded_c);
`else
    logic [SUM_W-1:0] trunc_c;
    assign trunc_c = sum >> LOG2_N;
    assign mean_c  = DATA_W'(trunc_c);
`endif

    // Accumulators and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v   <= 1'b0;
            pipe_a   <= '0;
            sum      <= '0;
            max_val  <= '0;
            max_addr <= '0;
            nz_cnt   <= '0;
            mean     <= '0;
        end else begin
            pipe_v <= crd_q;
            pipe_a <= caddr_q;
            if (clr_c) begin
                sum      <= '0;
                max_val  <= '0;
                max_addr <= '0;
                nz_cnt   <= '0;
                mean     <= '0;
            end else if (pipe_v) begin
                sum <= sum + SUM_W'(mem.cdata_rd);
                // Strict compare keeps the lowest address on ties.
                if (mem.cdata_rd > max_val) begin
                    max_val  <= mem.cdata_rd;
                    max_addr <= pipe_a;
                end
                if (mem.cdata_rd != '0) begin
                    nz_cnt <= nz_cnt + CNT_W'(1);
                end
            end
            if (fin_c) begin
                mean <= mean_c;
            end
        end
    end

endmodule

// File: tb/tb_layer1_stats.sv
// tb_layer1_stats: randomized and directed scans of layer1_stats against a
// behavioural model of the map statistics; memory modelled with 2-cycle read latency.
// Macro: LAYER1_STATS_ROUND_EN selects the rounded-mean expectation.
module tb_layer1_stats;
    localparam int unsigned N_WORDS = 1024;
    localparam int unsigned LOG2_N  = 10;
    localparam int unsigned LAT     = N_WORDS + 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [12:0] mean;
    logic [12:0] max_val;
    logic [9:0]  max_addr;
    logic [10:0] nz_cnt;

    layer1_stats_if bus ();

    layer1_stats #(.N_WORDS(N_WORDS), .LOG2_N(LOG2_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .mem      (bus),
        .done     (done),
        .mean     (mean),
        .max_val  (max_val),
        .max_addr (max_addr),
        .nz_cnt   (nz_cnt)
    );

    always #5 clk = ~clk;

    logic [12:0] mem_arr [N_WORDS];
    int          rd_cnt  [N_WORDS];
    int          bus_bad;
    int          done_pulses;
    int          checks = 0;
    int          errors = 0;

    // Memory: data for an address sampled at one edge appears after that edge;
    // junk is driven when not reading.
    always @(posedge clk) begin
        if (bus.crd) bus.cdata_rd <= mem_arr[bus.caddr_rd[9:0]];
        else         bus.cdata_rd <= 13'($urandom);
    end

    // Read-port and done-pulse monitor
    always @(negedge clk) begin
        if (bus.crd) begin
            rd_cnt[bus.caddr_rd[9:0]]++;
            if (!bus.csel || bus.caddr_rd[11:10] != 2'b00) bus_bad++;
        end
        if (done) done_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    int unsigned e_mean, e_max, e_addr, e_nz;

    // Statistics straight from the map contents
    task automatic model();
        longint unsigned s = 0;
        e_max = 0; e_addr = 0; e_nz = 0;
        for (int a = 0; a < N_WORDS; a++) begin
            s += mem_arr[a];
            if (mem_arr[a] > e_max) begin e_max = mem_arr[a]; e_addr = a; end
            if (mem_arr[a] != 0) e_nz++;
        end
`ifdef LAYER1_STATS_ROUND_EN
        e_mean = int'((s + N_WORDS / 2) / N_WORDS);
        if (e_mean > 4095) e_mean = 4095;
`else
        e_mean = int'(s / N_WORDS);
`endif
    endtask

    task automatic check_results(input string name);
        check({name, "_mean"},     32'(mean),     e_mean);
        check({name, "_max_val"},  32'(max_val),  e_max);
        check({name, "_max_addr"}, 32'(max_addr), e_addr);
        check({name, "_nz_cnt"},   32'(nz_cnt),   e_nz);
    endtask

    // One scan: start held for 'hold' cycles, then full result/timing checks.
    task automatic run_scan(input int hold, input string name);
        int lat = 0;
        int bad = 0;
        model();
        for (int a = 0; a < N_WORDS; a++) rd_cnt[a] = 0;
        bus_bad = 0;
        done_pulses = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, "_busy_start"}, 32'(busy), 1);
        if (hold <= 1) start = 1'b0;
        for (int i = 1; i <= 2 * N_WORDS && lat == 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i >= hold - 1) start = 1'b0;
            if (done) lat = i;
        end
        check({name, "_latency"}, 32'(lat), LAT);
        check({name, "_busy_in_done"}, 32'(busy), 1);
        check_results(name);
        // start during the done cycle must not launch a scan
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_after"}, 32'(busy), 0);
        check({name, "_csel_after"}, 32'(bus.csel), 0);
        repeat (4) @(negedge clk);
        check({name, "_done_pulses"}, 32'(done_pulses), 1);
        check({name, "_idle_crd"}, 32'(bus.crd), 0);
        for (int a = 0; a < N_WORDS; a++) if (rd_cnt[a] != 1) bad++;
        check({name, "_reads_once"}, 32'(bad), 0);
        check({name, "_bus_bad"}, 32'(bus_bad), 0);
        check_results({name, "_hold"});
    endtask

    task automatic fill_random(input int unsigned maxv, input int unsigned zero_odds);
        for (int a = 0; a < N_WORDS; a++)
            mem_arr[a] = ($urandom_range(0, zero_odds) == 0) ? 13'h0 : 13'($urandom_range(0, maxv));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int a = 0; a < N_WORDS; a++) mem_arr[a] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_crd", 32'(bus.crd), 0);
        check("rst_csel", 32'(bus.csel), 0);
        check("rst_done", 32'(done), 0);
        check("rst_caddr", 32'(bus.caddr_rd), 0);
        check("rst_mean", 32'(mean), 0);
        check("rst_max_val", 32'(max_val), 0);
        check("rst_max_addr", 32'(max_addr), 0);
        check("rst_nz_cnt", 32'(nz_cnt), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // All-zero map
        run_scan(1, "zero");

        // Ramp map: word[a] = a
        for (int a = 0; a < N_WORDS; a++) mem_arr[a] = 13'(a);
        run_scan(1, "ramp");

        // Two equal peaks: lower address wins
        for (int a = 0; a < N_WORDS; a++) mem_arr[a] = '0;
        mem_arr[5]   = 13'h0ABC;
        mem_arr[900] = 13'h0ABC;
        run_scan(1, "peaks");

        // Dense random map with start held for 200 cycles
        fill_random(4095, 3);
        run_scan(200, "held");

        // Small-range map: many ties on the maximum
        fill_random(15, 2);
        run_scan(1, "ties");

        // Reset in the middle of a scan
        fill_random(4095, 4);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (399) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 32'(busy), 0);
        check("abort_crd", 32'(bus.crd), 0);
        check("abort_csel", 32'(bus.csel), 0);
        check("abort_mean", 32'(mean), 0);
        check("abort_max_val", 32'(max_val), 0);
        check("abort_max_addr", 32'(max_addr), 0);
        check("abort_nz_cnt", 32'(nz_cnt), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_scan(1, "post_abort");

        // Back-to-back scans: large-valued map then a sparse small one
        fill_random(4095, 1);
        mem_arr[N_WORDS - 1] = 13'h0FFF;
        run_scan(1, "b2b_a");
        for (int a = 0; a < N_WORDS; a++) mem_arr[a] = '0;
        for (int k = 0; k < 8; k++) mem_arr[$urandom_range(0, N_WORDS - 1)] = 13'($urandom_range(1, 7));
        run_scan(1, "b2b_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
